csr_ddr3_pulse_sync: RTL and testbench



---
 rtl/csr_ddr3_pkg.sv | 44 ++++
 rtl/csr_ddr3_sync_bit.sv | 40 ++++
 rtl/csr_ddr3_pulse_sync.sv | 48 ++++
 tb/tb_csr_ddr3_pulse_sync.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/csr_ddr3_pkg.sv
// Shared constants for the csr_ddr3 block: sync depth default, CSR map, MIG commands.
// CSR_DDR3_PULSE_SYNC_EXTRA_STAGE_EN adds one metastability flop to every event sync chain.
package csr_ddr3_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [7:0] {
    CSR_CTRL = 8'h00,
    CSR_STAT = 8'h04,
    CSR_ADDR = 8'h08,
    CSR_W0   = 8'h10,
    CSR_W1   = 8'h14,
    CSR_W2   = 8'h18,
    CSR_W3   = 8'h1C,
    CSR_W4   = 8'h20,
    CSR_W5   = 8'h24,
    CSR_W6   = 8'h28,
    CSR_W7   = 8'h2C,
    CSR_R0   = 8'h30,
    CSR_R1   = 8'h34,
    CSR_R2   = 8'h38,
    CSR_R3   = 8'h3C,
    CSR_R4   = 8'h40,
    CSR_R5   = 8'h44,
    CSR_R6   = 8'h48,
    CSR_R7   = 8'h4C,
    CSR_GWTC = 8'h50,
    CSR_GRTC = 8'h54
  } csr_offset_e;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'b000,
    CMD_READ  = 3'b001
  } mig_cmd_e;

  function automatic int unsigned sync_chain_len(input int unsigned stages);
`ifdef CSR_DDR3_PULSE_SYNC_EXTRA_STAGE_EN
    return stages + 1;
`else
    return stages;
`endif
  endfunction

endpackage

// File: rtl/csr_ddr3_sync_bit.sv
// Single-channel toggle synchroniser: metastability chain, edge register, gated pulse.
module csr_ddr3_sync_bit
  import csr_ddr3_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  input  logic armed_i,
  output logic pulse_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              edge_q;
  logic              pulse_q;
  logic              pulse_d;

  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], d_i};
    // The edge register keeps tracking while disarmed so a pre-existing level never pulses.
    pulse_d = (sync_q[STAGES-1] ^ edge_q) & armed_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= sync_q[STAGES-1];
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/csr_ddr3_pulse_sync.sv
// Toggle-to-pulse event synchroniser into clk2, WIDTH independent channels, shared arming counter.
// CSR_DDR3_PULSE_SYNC_EXTRA_STAGE_EN lengthens each chain by one flop and the arming count by one.
module csr_ddr3_pulse_sync
  import csr_ddr3_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o
);

  localparam int unsigned CHAIN_LEN = sync_chain_len(SYNC_STAGES);
  localparam int unsigned ARM_COUNT = CHAIN_LEN + 1;
  localparam int unsigned CW        = $clog2(ARM_COUNT + 1);

  logic [CW-1:0] arm_cnt_q;
  logic [CW-1:0] arm_cnt_d;
  logic          armed;

  always_comb begin
    armed     = (arm_cnt_q == CW'(ARM_COUNT));
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CW'(1);
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt_q <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    csr_ddr3_sync_bit #(
      .STAGES(CHAIN_LEN)
    ) u_sync (
      .clk_i   (clk2),
      .rst_ni  (rst_n),
      .d_i     (i[g]),
      .armed_i (armed),
      .pulse_o (o[g])
    );
  end

endmodule

// File: tb/tb_csr_ddr3_pulse_sync.sv
// Directed bench for csr_ddr3_pulse_sync (WIDTH=2) with a cycle-stamped expected-pulse queue.
module tb_csr_ddr3_pulse_sync;

`ifdef CSR_DDR3_PULSE_SYNC_EXTRA_STAGE_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 2;
`endif

  logic       clk2  = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] i     = 2'b00;
  logic [1:0] o;

  csr_ddr3_pulse_sync #(
    .WIDTH       (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk2  (clk2),
    .rst_n (rst_n),
    .i     (i),
    .o     (o)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  val;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc     = 0;
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          pulses0 = 0;
  bit          mon_en  = 1'b1;
  logic [1:0]  mon_exp;

  always @(posedge clk2) cyc++;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample 2 time units after each rising edge; every cycle o must match the queue head or be 0.
  always @(posedge clk2) begin
    #2;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("missed_pulse", 2'b00, q[0].val);
        void'(q.pop_front());
      end
      mon_exp = 2'b00;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_exp = q[0].val;
        void'(q.pop_front());
      end
      check("o_cycle", o, mon_exp);
      if (o[0] === 1'b1) pulses0++;
    end
  end

  task automatic push_exp(input int unsigned c, input logic [1:0] v);
    if (q.size() > 0 && q[q.size()-1].cyc == c) q[q.size()-1].val |= v;
    else q.push_back('{cyc: c, val: v});
  endtask

  task automatic toggle(input logic [1:0] mask);
    @(negedge clk2);
    i = i ^ mask;
    push_exp(cyc + 1 + LAT, mask);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk2);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk2);
    rst_n = 1'b0;
    q.delete();
    #1 check("reset_async_o", o, 2'b00);
    wait_cyc(hold);
    @(negedge clk2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset and single toggle
    wait_cyc(3);
    check("reset_o", o, 2'b00);
    @(negedge clk2);
    rst_n = 1'b1;
    wait_cyc(5);
    toggle(2'b01);
    wait_cyc(8);

    // Level already high across reset release: no pulse, then falling toggle pulses once
    @(negedge clk2);
    rst_n = 1'b0;
    q.delete();
    i = 2'b01;
    #1 check("prearm_reset_o", o, 2'b00);
    wait_cyc(3);
    @(negedge clk2);
    rst_n = 1'b1;
    pulses0 = 0;
    wait_cyc(20);
    check_int("prearm_no_pulse", pulses0, 0);
    toggle(2'b01);
    wait_cyc(8);
    check_int("prearm_one_pulse", pulses0, 1);

    // Ten toggles four cycles apart
    @(negedge clk2);
    pulses0 = 0;
    repeat (10) begin
      toggle(2'b01);
      wait_cyc(3);
    end
    wait_cyc(8);
    check_int("b2b_pulse_count", pulses0, 10);

    // Independent channels
    toggle(2'b11);
    wait_cyc(8);
    toggle(2'b10);
    wait_cyc(8);

    // Reset one cycle after a toggle drops the event; re-armed toggle pulses once
    @(negedge clk2);
    pulses0 = 0;
    toggle(2'b01);
    do_reset(2);
    wait_cyc(8);
    check_int("midreset_dropped", pulses0, 0);
    toggle(2'b01);
    wait_cyc(8);
    check_int("rearm_one_pulse", pulses0, 1);

    check_int("queue_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
